// File: rtl/blake512_pkg.sv
// Shared constants and state encoding for the BLAKE-512 feeder and round controller.
package blake512_pkg;

    localparam int WORD_W      = 64;
    localparam int BLK_WORDS   = 16;
    localparam int DIG_WORDS   = 8;
    localparam int BLK_BITS    = 1024;
    localparam int CTRL_ROUNDS = 128;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/blake512_digest_ser.sv
// Captures the 512-bit chaining value and streams it out as eight 64-bit words
// with valid/ready handshaking; word 0 is the most significant word.
module blake512_digest_ser
    import blake512_pkg::*;
(
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          cap_i,
    input  logic [DIG_WORDS*WORD_W-1:0]   digest_i,
    input  logic                          act_i,
    input  logic                          m_ready_i,
    output logic                          m_valid_o,
    output logic [WORD_W-1:0]             m_data_o,
    output logic                          m_last_o,
    output logic                          done_o
);

    logic [DIG_WORDS*WORD_W-1:0] dig_q;
    logic [2:0]                  out_cnt_q;
    logic [2:0]                  out_cnt_d;
    logic [WORD_W-1:0]           dig_words [DIG_WORDS];
    logic                        xfer;

    always_comb begin
        for (int i = 0; i < DIG_WORDS; i++) begin
            dig_words[i] = dig_q[(DIG_WORDS-1-i)*WORD_W +: WORD_W];
        end
    end

    assign xfer      = act_i && m_ready_i;
    assign out_cnt_d = xfer ? out_cnt_q + 3'd1 : out_cnt_q;
    assign m_valid_o = act_i;
    assign m_data_o  = act_i ? dig_words[out_cnt_q] : '0;
    assign m_last_o  = act_i && (out_cnt_q == 3'd7);
    assign done_o    = xfer && (out_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dig_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            if (cap_i) begin
                dig_q <= digest_i;
            end
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: rtl/blake512_feeder.sv
// Host-side driver for the BLAKE-512 round controller: assembles 1024-bit blocks,
// issues one compression per block, tracks t/first/last and emits the final digest.
module blake512_feeder #(
    parameter int T_W      = 128,
    parameter int BLK_BITS = 1024
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [63:0]     s_data,
    input  logic            s_last,
    output logic            core_ena,
    output logic [1023:0]   core_msg,
    output logic [T_W-1:0]  core_t,
    output logic            core_first,
    input  logic            core_fin,
    input  logic            core_clr,
    input  logic [511:0]    core_digest,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [63:0]     m_data,
    output logic            m_last,
    output logic            err
);
    import blake512_pkg::*;

    feeder_state_e     state_q, state_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
    logic [T_W-1:0]    t_q, t_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] msg_q [BLK_WORDS];
    logic              wr_en;
    logic              cap;
    logic              ser_done;
    logic              proto_err;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Bad handshakes only raise the sticky flag; the FSM ignores them.
    assign proto_err = (core_fin && state_q != ST_BUSY)
                    || (core_clr && state_q != ST_DRAIN)
                    || (state_q == ST_LOAD && s_valid && s_last && word_cnt_q != 4'd15);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        t_d        = t_q;
        first_d    = first_q;
        last_d     = last_q;
        err_d      = err_q || proto_err;
        s_ready    = 1'b0;
        core_ena   = 1'b0;
        wr_en      = 1'b0;
        cap        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_en      = 1'b1;
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == 4'd15) begin
                        last_d  = s_last;
                        t_d     = t_q + T_W'(BLK_BITS);
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                core_ena = 1'b1;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_fin) begin
                    cap     = last_q;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (core_clr) begin
                    first_d = 1'b0;
                    state_d = last_q ? ST_OUT : ST_LOAD;
                end
            end
            ST_OUT: begin
                if (ser_done) begin
                    t_d     = '0;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            word_cnt_q <= '0;
            t_q        <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < BLK_WORDS; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            word_cnt_q <= word_cnt_d;
            t_q        <= t_d;
            first_q    <= first_d;
            last_q     <= last_d;
            err_q      <= err_d;
            if (wr_en) begin
                msg_q[word_cnt_q] <= s_data;
            end
        end
    end

    always_comb begin
        core_msg = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            core_msg[(BLK_WORDS-1-i)*WORD_W +: WORD_W] = msg_q[i];
        end
    end

    assign core_t     = t_q;
    assign core_first = first_q;
    assign err        = err_q;

    blake512_digest_ser u_ser (
        .clk       (clk),
        .rstb      (rstb),
        .cap_i     (cap),
        .digest_i  (core_digest),
        .act_i     (state_q == ST_OUT),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .done_o    (ser_done)
    );

endmodule

// File: tb/tb_blake512_feeder.sv
// Scenario bench for blake512_feeder with a hand-driven controller model and a digest scoreboard.
module tb_blake512_feeder;
    import blake512_pkg::*;

    logic          clk = 1'b0;
    logic          rstb;
    logic          s_valid, s_ready, s_last;
    logic [63:0]   s_data;
    logic          core_ena, core_first, core_fin, core_clr;
    logic [1023:0] core_msg;
    logic [127:0]  core_t;
    logic [511:0]  core_digest;
    logic          m_valid, m_ready, m_last, err;
    logic [63:0]   m_data;

    int checks = 0;
    int errors = 0;
    int ena_cnt = 0;
    logic [64:0] exp_q [$];
    logic [64:0] e;
    logic [63:0] exp_words [16];

    blake512_feeder #(.T_W(128), .BLK_BITS(1024)) dut (
        .clk(clk), .rstb(rstb), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .core_ena(core_ena), .core_msg(core_msg), .core_t(core_t),
        .core_first(core_first), .core_fin(core_fin), .core_clr(core_clr),
        .core_digest(core_digest), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .err(err)
    );

    always #5 clk = ~clk;

    // Output scoreboard: every accepted digest word must match the next expected one.
    always @(negedge clk) begin
        if (core_ena) ena_cnt++;
        if (rstb && m_valid) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL s_ready_in_out got %0b want 0", s_ready);
            end
            if (m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL digest_word got last=%0b %h want last=%0b %h",
                                 m_last, m_data, e[64], e[63:0]);
                    end
                end
            end
        end
    end

    function automatic logic [511:0] make_dig(input logic [31:0] seed);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[(7-i)*64 +: 64] = {seed, 32'h0D16_0000 + i};
        return d;
    endfunction

    function automatic logic [1023:0] exp_msg();
        logic [1023:0] m;
        for (int k = 0; k < 16; k++) m[(15-k)*64 +: 64] = exp_words[k];
        return m;
    endfunction

    task automatic push_dig(input logic [511:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), d[(7-i)*64 +: 64]});
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    // Streams 16 words base+k back to back; s_last is raised on word last_pos (16 = never).
    task automatic send_block(input logic [63:0] base, input int last_pos);
        for (int k = 0; k < 16; k++) begin
            exp_words[k] = base + 64'(k);
            s_valid = 1'b1;
            s_data  = exp_words[k];
            s_last  = (k == last_pos);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Controller model: fin 128 cycles after ena, clr the cycle after fin.
    task automatic run_core(input logic [511:0] dig, input bit push);
        int n;
        n = 0;
        while (!core_ena && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!core_ena) begin
            errors++;
            $display("FAIL ena_timeout got 0 want 1");
            return;
        end
        repeat (CTRL_ROUNDS) @(posedge clk);
        #1;
        core_fin    = 1'b1;
        core_digest = dig;
        if (push) push_dig(dig);
        @(posedge clk);
        #1 core_fin = 1'b0;
        core_clr = 1'b1;
        @(posedge clk);
        #1 core_clr = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || s_ready !== 1'b1 || core_t !== '0 || core_first !== 1'b1) begin
            errors++;
            $display("FAIL drain_done left=%0d s_ready=%0b t=%0d first=%0b want 0 1 0 1",
                     exp_q.size(), s_ready, core_t, core_first);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_ready !== 1'b1 || core_first !== 1'b1 || core_ena !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got s_ready=%0b first=%0b ena=%0b m_valid=%0b want 1 1 0 0",
                     s_ready, core_first, core_ena, m_valid);
        end
        checks++;
        if (core_t !== '0 || err !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || core_msg !== '0) begin
            errors++;
            $display("FAIL reset_data got t=%0d err=%0b m_data=%h m_last=%0b want zeros",
                     core_t, err, m_data, m_last);
        end
    endtask

    task automatic test_single_block();
        int e0;
        e0 = ena_cnt;
        send_block(64'h0, 15);
        checks++;
        if (core_ena !== 1'b1 || core_t !== 128'd1024 || core_first !== 1'b1) begin
            errors++;
            $display("FAIL single_start got ena=%0b t=%0d first=%0b want 1 1024 1",
                     core_ena, core_t, core_first);
        end
        checks++;
        if (core_msg !== exp_msg()) begin
            errors++;
            $display("FAIL single_msg got %h want %h", core_msg[1023:960], exp_words[0]);
        end
        run_core(make_dig(32'hA1A1_0001), 1'b1);
        checks++;
        if (m_valid !== 1'b1 || ena_cnt - e0 != 1) begin
            errors++;
            $display("FAIL single_latency got m_valid=%0b enas=%0d want 1 1", m_valid, ena_cnt - e0);
        end
        wait_drain();
    endtask

    task automatic test_two_blocks();
        send_block(64'h100, 16);
        checks++;
        if (core_t !== 128'd1024 || core_first !== 1'b1) begin
            errors++;
            $display("FAIL blk1 got t=%0d first=%0b want 1024 1", core_t, core_first);
        end
        run_core(make_dig(32'hBAD0_BAD0), 1'b0);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || core_first !== 1'b0) begin
            errors++;
            $display("FAIL blk1_done got m_valid=%0b s_ready=%0b first=%0b want 0 1 0",
                     m_valid, s_ready, core_first);
        end
        send_block(64'h200, 15);
        checks++;
        if (core_ena !== 1'b1 || core_t !== 128'd2048 || core_first !== 1'b0) begin
            errors++;
            $display("FAIL blk2 got ena=%0b t=%0d first=%0b want 1 2048 0",
                     core_ena, core_t, core_first);
        end
        run_core(make_dig(32'hB2B2_0002), 1'b1);
        wait_drain();
    endtask

    task automatic test_back_pressure();
        logic [511:0] d;
        int stalls, n;
        d = make_dig(32'hC3C3_0003);
        stalls = 0;
        n = 0;
        send_block(64'h300, 15);
        run_core(d, 1'b1);
        while (exp_q.size() != 0 && n < 60) begin
            if (8 - exp_q.size() == 3 && stalls < 5) begin
                m_ready = 1'b0;
                stalls++;
                checks++;
                if (m_valid !== 1'b1 || m_data !== d[4*64 +: 64] || m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b %h last=%0b want 1 %h 0",
                             m_valid, m_data, m_last, d[4*64 +: 64]);
                end
            end else begin
                m_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        m_ready = 1'b1;
        checks++;
        if (stalls != 5) begin
            errors++;
            $display("FAIL stall_count got %0d want 5", stalls);
        end
        wait_drain();
    endtask

    task automatic test_gaps();
        int k, n;
        k = 0;
        n = 0;
        while (k < 16 && n < 64) begin
            s_valid = n[0];
            s_data  = 64'hA5A5_0000_0000_0000 ^ 64'(n * 3);
            s_last  = s_valid && (k == 15);
            if (s_valid) exp_words[k] = s_data;
            @(posedge clk);
            #1;
            if (s_valid) k++;
            n++;
            if (k < 16) begin
                checks++;
                if (core_ena !== 1'b0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_early got ena=%0b s_ready=%0b after %0d words want 0 1",
                             core_ena, s_ready, k);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (core_ena !== 1'b1 || core_msg !== exp_msg()) begin
            errors++;
            $display("FAIL gap_msg got ena=%0b w0=%h w15=%h want 1 %h %h", core_ena,
                     core_msg[1023:960], core_msg[63:0], exp_words[0], exp_words[15]);
        end
        run_core(make_dig(32'hD4D4_0004), 1'b1);
        wait_drain();
    endtask

    task automatic test_errors();
        core_fin = 1'b1;
        @(posedge clk);
        #1 core_fin = 1'b0;
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b1 || core_ena !== 1'b0) begin
            errors++;
            $display("FAIL fin_in_load got err=%0b s_ready=%0b ena=%0b want 1 1 0",
                     err, s_ready, core_ena);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got %0b want 0", err);
        end
        send_block(64'h500, 5);
        checks++;
        if (err !== 1'b1 || core_ena !== 1'b1) begin
            errors++;
            $display("FAIL slast_w5 got err=%0b ena=%0b want 1 1", err, core_ena);
        end
        run_core(make_dig(32'hE5E5_0005), 1'b0);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL slast_w5_notfinal got m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready);
        end
        do_reset();
    endtask

    task automatic test_reset_busy();
        send_block(64'h600, 15);
        repeat (61) @(posedge clk);
        #1 rstb = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || core_t !== '0 || core_first !== 1'b1 || core_ena !== 1'b0 ||
            m_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got s_ready=%0b t=%0d first=%0b ena=%0b m_valid=%0b err=%0b",
                     s_ready, core_t, core_first, core_ena, m_valid, err);
        end
        @(posedge clk);
        #1 rstb = 1'b1;
        send_block(64'h700, 15);
        checks++;
        if (core_t !== 128'd1024 || core_first !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got t=%0d first=%0b want 1024 1", core_t, core_first);
        end
        run_core(make_dig(32'hF6F6_0006), 1'b1);
        wait_drain();
    endtask

    initial begin
        rstb = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        core_fin = 1'b0;
        core_clr = 1'b0;
        core_digest = '0;
        m_ready = 1'b1;
        test_reset();
        test_single_block();
        test_two_blocks();
        test_back_pressure();
        test_gaps();
        test_errors();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
